// File: rtl/not_not_judge_pkg.sv
// Shared Not Not definitions: round FSM states, verdict LED codes, colour switch indices
// and the answer-grading rule used by the judge.
package not_not_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_ANSWER,
    ST_JUDGE,
    ST_SHOW,
    ST_OVER
  } state_e;

  localparam logic [1:0] VERDICT_NONE    = 2'b00;
  localparam logic [1:0] VERDICT_CORRECT = 2'b01;
  localparam logic [1:0] VERDICT_WRONG   = 2'b10;

  // Bit positions in expected_mask / player_sw, shared with the prompt generator
  localparam int COL_RED    = 0;
  localparam int COL_GREEN  = 1;
  localparam int COL_BLUE   = 2;
  localparam int COL_YELLOW = 3;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // An empty mask means "do nothing": only letting the timer run out is correct.
  function automatic logic answer_ok(input logic [3:0] mask, input logic [3:0] sw,
                                     input logic submitted);
    if (mask == 4'b0000) return !submitted;
    return submitted && is_onehot4(sw) && ((sw & mask) != 4'b0000);
  endfunction

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD counter, saturating at 99; clear and inc take effect on the next clock.
// Sync active-high reset; clear has priority over inc; no backpressure.
module bcd_counter_2d (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] value
);

  logic [3:0] ones_q;
  logic [3:0] tens_q;
  logic       at_max_d;

  assign at_max_d = (tens_q == 4'd9) && (ones_q == 4'd9);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else if (inc && !at_max_d) begin
      if (ones_q == 4'd9) begin
        ones_q <= 4'd0;
        tens_q <= tens_q + 4'd1;
      end else begin
        ones_q <= ones_q + 4'd1;
      end
    end
  end

  assign value = {tens_q, ones_q};

endmodule

// File: rtl/not_not_judge.sv
// Not Not round judge: captures the player's answer, grades it, keeps score/lives, asks for prompts.
// All outputs registered; verdict pulses one cycle after JUDGE; no backpressure (prompts only accepted in ARMED).
module not_not_judge
  import not_not_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int SHOW_CYCLES    = 25000000,
  parameter int LIVES          = 3,
  parameter int TIMER_W        = 27
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         expected_mask,
  input  logic               prompt_valid,
  input  logic [3:0]         player_sw,
  input  logic               submit,
  output logic               next_prompt,
  output logic               correct,
  output logic               wrong,
  output logic [1:0]         verdict_led,
  output logic [7:0]         score_bcd,
  output logic [1:0]         lives,
  output logic [TIMER_W-1:0] time_left,
  output logic               game_over
);

  localparam logic [TIMER_W-1:0] TIMEOUT_RELOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SHOW_RELOAD    = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [1:0]         LIVES_INIT     = 2'(LIVES);

  state_e             state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [3:0]         mask_q;
  logic [3:0]         sw_q;
  logic               submitted_q;
  logic               sub_prev_q;
  logic [1:0]         lives_q;
  logic [1:0]         verdict_q;
  logic               next_prompt_q;
  logic               correct_q;
  logic               wrong_q;
  logic               game_over_q;

  logic submit_edge_d;
  logic judge_ok_d;
  logic score_inc_d;

  assign submit_edge_d = submit && !sub_prev_q;
  assign judge_ok_d    = answer_ok(mask_q, sw_q, submitted_q);
  assign score_inc_d   = !start && (state_q == ST_JUDGE) && judge_ok_d;

  bcd_counter_2d u_score (
    .clock (clock),
    .reset (reset),
    .clear (start),
    .inc   (score_inc_d),
    .value (score_bcd)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      mask_q        <= 4'b0000;
      sw_q          <= 4'b0000;
      submitted_q   <= 1'b0;
      sub_prev_q    <= 1'b0;
      lives_q       <= 2'd0;
      verdict_q     <= VERDICT_NONE;
      next_prompt_q <= 1'b0;
      correct_q     <= 1'b0;
      wrong_q       <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      next_prompt_q <= 1'b0;
      correct_q     <= 1'b0;
      wrong_q       <= 1'b0;
      if (start) begin
        state_q       <= ST_ARMED;
        timer_q       <= '0;
        lives_q       <= LIVES_INIT;
        verdict_q     <= VERDICT_NONE;
        game_over_q   <= 1'b0;
        next_prompt_q <= 1'b1;
      end else begin
        case (state_q)
          ST_ARMED: begin
            if (prompt_valid) begin
              mask_q     <= expected_mask;
              timer_q    <= TIMEOUT_RELOAD;
              sub_prev_q <= 1'b0;
              state_q    <= ST_ANSWER;
            end
          end
          ST_ANSWER: begin
            sub_prev_q <= submit;
            // A submit edge on the final cycle still counts as an answer
            if (submit_edge_d) begin
              sw_q        <= player_sw;
              submitted_q <= 1'b1;
              state_q     <= ST_JUDGE;
            end else if (timer_q == '0) begin
              submitted_q <= 1'b0;
              state_q     <= ST_JUDGE;
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
          ST_JUDGE: begin
            correct_q <= judge_ok_d;
            wrong_q   <= !judge_ok_d;
            verdict_q <= judge_ok_d ? VERDICT_CORRECT : VERDICT_WRONG;
            if (!judge_ok_d && (lives_q != 2'd0)) lives_q <= lives_q - 2'd1;
            timer_q   <= SHOW_RELOAD;
            state_q   <= ST_SHOW;
          end
          ST_SHOW: begin
            if (timer_q == '0) begin
              verdict_q <= VERDICT_NONE;
              if (lives_q == 2'd0) begin
                game_over_q <= 1'b1;
                state_q     <= ST_OVER;
              end else begin
                next_prompt_q <= 1'b1;
                state_q       <= ST_ARMED;
              end
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign next_prompt = next_prompt_q;
  assign correct     = correct_q;
  assign wrong       = wrong_q;
  assign verdict_led = verdict_q;
  assign lives       = lives_q;
  assign game_over   = game_over_q;
  assign time_left   = (state_q == ST_ANSWER) ? timer_q : '0;

endmodule

// File: tb/tb_not_not_judge.sv
// Bench for not_not_judge: round-level game model turned into a per-cycle event schedule,
// compared against the DUT every cycle, plus literal spot checks.
module tb_not_not_judge;

  localparam int TO = 20;
  localparam int SH = 4;
  localparam int LV = 3;
  localparam int TW = 27;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    expected_mask = 4'b0000;
  logic          prompt_valid = 1'b0;
  logic [3:0]    player_sw = 4'b0000;
  logic          submit = 1'b0;
  logic          next_prompt, correct, wrong, game_over;
  logic [1:0]    verdict_led, lives;
  logic [7:0]    score_bcd;
  logic [TW-1:0] time_left;

  not_not_judge #(
    .TIMEOUT_CYCLES(TO), .SHOW_CYCLES(SH), .LIVES(LV), .TIMER_W(TW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .expected_mask(expected_mask),
    .prompt_valid(prompt_valid), .player_sw(player_sw), .submit(submit),
    .next_prompt(next_prompt), .correct(correct), .wrong(wrong),
    .verdict_led(verdict_led), .score_bcd(score_bcd), .lives(lives),
    .time_left(time_left), .game_over(game_over)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected-output events, keyed by the cycle in which they become visible
  localparam int K_SCORE = 0, K_LIVES = 1, K_LED = 2, K_OVER = 3, K_TLON = 4;
  localparam int K_TLOFF = 5, K_COR = 6, K_WRG = 7, K_NP = 8;
  typedef struct { int at; int kind; int val; } ev_t;
  ev_t sched[$];

  task automatic post(input int at, input int kind, input int val);
    ev_t e;
    e.at = at; e.kind = kind; e.val = val;
    sched.push_back(e);
  endtask

  task automatic drop_future();
    for (int i = sched.size() - 1; i >= 0; i--)
      if (sched[i].at > cyc) sched.delete(i);
  endtask

  bit chk_en = 1'b0;
  int e_score = 0, e_lives = 0, e_led = 0, e_over = 0, tl_base = 0;
  bit tl_on = 1'b0;

  always @(negedge clock) begin
    bit pc, pw, pn;
    int i, e_tl;
    pc = 1'b0; pw = 1'b0; pn = 1'b0;
    i = 0;
    while (i < sched.size()) begin
      if (sched[i].at == cyc) begin
        case (sched[i].kind)
          K_SCORE: e_score = sched[i].val;
          K_LIVES: e_lives = sched[i].val;
          K_LED:   e_led   = sched[i].val;
          K_OVER:  e_over  = sched[i].val;
          K_TLON:  begin tl_on = 1'b1; tl_base = cyc; end
          K_TLOFF: tl_on = 1'b0;
          K_COR:   pc = 1'b1;
          K_WRG:   pw = 1'b1;
          K_NP:    pn = 1'b1;
          default: ;
        endcase
        sched.delete(i);
      end else begin
        i++;
      end
    end
    if (chk_en) begin
      e_tl = tl_on ? (TO - 1 - (cyc - tl_base)) : 0;
      check("correct", 32'(correct), 32'(pc));
      check("wrong", 32'(wrong), 32'(pw));
      check("next_prompt", 32'(next_prompt), 32'(pn));
      check("score_bcd", 32'(score_bcd), 32'(((e_score / 10) << 4) | (e_score % 10)));
      check("lives", 32'(lives), 32'(e_lives));
      check("verdict_led", 32'(verdict_led), 32'(e_led));
      check("game_over", 32'(game_over), 32'(e_over));
      check("time_left", 32'(time_left), 32'(e_tl));
    end
  end

  // Round-level game model
  int m_score = 0;
  int m_lives = 0;

  function automatic bit model_ok(input logic [3:0] mask, input logic [3:0] sw, input bit sub);
    int ones;
    ones = 0;
    for (int b = 0; b < 4; b++) ones += int'(sw[b]);
    if (mask == 4'b0000) return !sub;
    return sub && (ones == 1) && ((sw & mask) != 4'b0000);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_start();
    int s;
    s = cyc;
    start = 1'b1;
    drop_future();
    m_score = 0;
    m_lives = LV;
    post(s + 1, K_SCORE, 0); post(s + 1, K_LIVES, LV); post(s + 1, K_LED, 0);
    post(s + 1, K_OVER, 0);  post(s + 1, K_NP, 1);     post(s + 1, K_TLOFF, 0);
    tick(1);
    start = 1'b0;
  endtask

  // Answer in ANSWER cycle k (1-based); k == TO with sub=0 is a plain timeout
  task automatic round(input logic [3:0] mask, input logic [3:0] sw, input int k, input bit sub);
    int p;
    bit ok;
    p = cyc;
    expected_mask = mask;
    prompt_valid  = 1'b1;
    ok = model_ok(mask, sw, sub);
    if (ok) m_score = (m_score >= 99) ? 99 : m_score + 1;
    else if (m_lives > 0) m_lives--;
    post(p + 1, K_TLON, 0);
    post(p + k + 1, K_TLOFF, 0);
    post(p + k + 2, ok ? K_COR : K_WRG, 1);
    post(p + k + 2, K_SCORE, m_score);
    post(p + k + 2, K_LIVES, m_lives);
    post(p + k + 2, K_LED, ok ? 1 : 2);
    post(p + k + 2 + SH, K_LED, 0);
    if (m_lives == 0) post(p + k + 2 + SH, K_OVER, 1);
    else              post(p + k + 2 + SH, K_NP, 1);
    tick(1);
    prompt_valid = 1'b0;
    if (sub) begin
      tick(k - 1);
      player_sw = sw;
      submit    = 1'b1;
      tick(1);
      submit = 1'b0;
      tick(SH + 1);
    end else begin
      tick(k + SH + 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    tick(2);
    chk_en = 1'b1;
    check("reset_score", 32'(score_bcd), 32'h00);
    check("reset_lives", 32'(lives), 32'd0);
    check("reset_over", 32'(game_over), 32'd0);
    reset = 1'b0;
    tick(1);

    do_start();
    check("lit_start_lives", 32'(lives), 32'd3);
    round(4'b0010, 4'b0010, 5, 1'b1);
    check("lit_score_after_correct", 32'(score_bcd), 32'h01);
    check("lit_np_after_show", 32'(next_prompt), 32'd1);
    round(4'b1101, 4'b0011, 3, 1'b1);
    check("lit_lives_after_wrong", 32'(lives), 32'd2);
    check("lit_score_unchanged", 32'(score_bcd), 32'h01);
    round(4'b0000, 4'b0000, TO, 1'b0);
    check("lit_empty_mask_timeout", 32'(score_bcd), 32'h02);
    round(4'b0000, 4'b0001, 4, 1'b1);
    check("lit_empty_mask_submit", 32'(lives), 32'd1);
    round(4'b0100, 4'b0100, TO, 1'b1);
    check("lit_edge_at_timer0", 32'(score_bcd), 32'h03);

    do_start();
    round(4'b0001, 4'b0000, 2, 1'b1);
    round(4'b0010, 4'b0001, 6, 1'b1);
    round(4'b1000, 4'b0000, TO, 1'b0);
    check("lit_over", 32'(game_over), 32'd1);
    check("lit_over_lives", 32'(lives), 32'd0);
    for (int i = 0; i < 3; i++) begin
      expected_mask = 4'b0001; prompt_valid = 1'b1; player_sw = 4'b0001; submit = 1'b1;
      tick(1);
      prompt_valid = 1'b0; submit = 1'b0;
      tick(7);
    end
    check("lit_over_frozen", 32'(game_over), 32'd1);

    do_start();
    check("lit_restart_score", 32'(score_bcd), 32'h00);
    check("lit_restart_lives", 32'(lives), 32'd3);
    for (int i = 0; i < 99; i++) begin
      round(4'b0001, 4'b0001, 1, 1'b1);
      if (i == 8) check("lit_score_09", 32'(score_bcd), 32'h09);
      if (i == 9) check("lit_score_10", 32'(score_bcd), 32'h10);
    end
    check("lit_score_99", 32'(score_bcd), 32'h99);
    round(4'b1000, 4'b1000, 2, 1'b1);
    check("lit_score_sat", 32'(score_bcd), 32'h99);

    p = cyc;
    expected_mask = 4'b0010;
    prompt_valid  = 1'b1;
    post(p + 1, K_TLON, 0);
    tick(1);
    prompt_valid = 1'b0;
    tick(3);
    check("lit_time_left_mid", 32'(time_left), 32'd16);
    reset = 1'b1;
    drop_future();
    m_score = 0;
    m_lives = 0;
    post(cyc + 1, K_SCORE, 0); post(cyc + 1, K_LIVES, 0); post(cyc + 1, K_LED, 0);
    post(cyc + 1, K_OVER, 0);  post(cyc + 1, K_TLOFF, 0);
    tick(1);
    check("lit_rst_score", 32'(score_bcd), 32'h00);
    check("lit_rst_time_left", 32'(time_left), 32'd0);
    check("lit_rst_lives", 32'(lives), 32'd0);
    tick(1);
    reset = 1'b0;
    expected_mask = 4'b0100;
    prompt_valid  = 1'b1;
    tick(1);
    prompt_valid = 1'b0;
    tick(25);
    check("lit_idle_ignores_prompt", 32'(time_left), 32'd0);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/not_not_judge.md
Name: not_not_judge

Overview:
- Player-side end of the Not Not round: takes the expected answer mask produced by the prompt generator, then times and captures the player's switch/KEY response.
- Grades the response, maintains the BCD score and lives, and requests the next prompt.
- Sits between the prompt generator (mask source) and the top level (SW/KEY inputs, HEX/LED outputs).

Parameters:
- TIMEOUT_CYCLES, 100000000, answer window per round in clock cycles (2 s at 50 MHz); minimum 2.
- SHOW_CYCLES, 25000000, cycles the verdict is held before the next round; minimum 1.
- LIVES, 3, lives at game start; range 1..3.
- TIMER_W, 27, counter width; must hold max(TIMEOUT_CYCLES, SHOW_CYCLES).

Ports:
- clock  in  1  CLOCK_50 domain clock
- reset  in  1  synchronous, active-high; forces IDLE and clears all outputs
- start  in  1  level-sensitive; any cycle it is high restarts the game
- expected_mask  in  4  one bit per colour switch; a set bit means that switch is a correct answer
- prompt_valid  in  1  1-cycle pulse; expected_mask is valid in that cycle
- player_sw  in  4  colour switches SW[3:0], already synchronised
- submit  in  1  active-high submit level (inverted KEY), already synchronised
- next_prompt  out  1  1-cycle request for a new prompt
- correct  out  1  1-cycle pulse, round graded correct
- wrong  out  1  1-cycle pulse, round graded wrong
- verdict_led  out  2  held during SHOW: 2'b01 correct, 2'b10 wrong, else 2'b00
- score_bcd  out  8  two BCD digits, tens in [7:4]
- lives  out  2  remaining lives
- time_left  out  TIMER_W  remaining answer cycles; 0 outside ANSWER
- game_over  out  1  high in OVER

Behaviour:
- Reset: state IDLE; all outputs 0; score_bcd=8'h00; lives=0.
- Clock and reset: one clock; reset is synchronous and active-high; ports are named clock and reset.
- start high in any state (reset absent):
  - next cycle, score_bcd=0, lives=LIVES, next_prompt pulses, state ARMED.
  - start has priority over every other event except reset.
- ARMED:
  - on prompt_valid, latch expected_mask, set timer=TIMEOUT_CYCLES-1, go ANSWER.
  - prompt_valid in any other state is ignored.
- ANSWER:
  - time_left=timer; timer decrements each cycle.
  - submit rising edge (submit=1 and previous-cycle submit=0): latch player_sw, mark submitted, go JUDGE.
  - Edge detector register is cleared on entry to ANSWER, so a submit already held at entry counts as an edge in the first ANSWER cycle.
  - timer==0 with no edge: mark not-submitted, go JUDGE.
  - An edge in the same cycle as timer==0 wins and is a submission.
- JUDGE (exactly 1 cycle; correct/wrong pulse in the cycle after JUDGE, registered):
  - mask!=0: correct iff submitted, popcount(sw)==1, and (sw & mask)!=0.
  - mask==0: correct iff not submitted, i.e. the correct move is to let the timer expire.
  - Timeout with a non-zero mask is wrong.
  - Correct: score_bcd increments in BCD (09->10, 99 saturates at 99).
  - Wrong: lives decrements, floor 0.
  - Next state SHOW; timer=SHOW_CYCLES-1.
- SHOW:
  - verdict_led held; timer decrements.
  - At 0: if lives==0 go OVER, else pulse next_prompt and go ARMED.
- OVER: game_over=1; score and lives frozen; leave only on start or reset.
- IDLE: waits for start.
- Reset mid-round discards the latched mask and edge history.

Decomposition:
- Shared package (not_not_pkg):
  - state enum (IDLE, ARMED, ANSWER, JUDGE, SHOW, OVER)
  - verdict_led codes
  - colour index constants shared with the prompt generator
- Sub-module bcd_counter_2d: clock, reset, clear, inc; saturates at 99; also reused for the top-level HEX score display.

Test Plan (TIMEOUT_CYCLES=20, SHOW_CYCLES=4, LIVES=3):
- start pulse, then prompt_valid with mask=4'b0010; submit edge with sw=4'b0010 on ANSWER cycle 5 -> correct pulses once, verdict_led=01 for 4 cycles, score_bcd=8'h01, next_prompt pulses.
- mask=4'b1101, sw=4'b0011 submitted -> wrong (popcount 2), lives 3->2, score unchanged.
- mask=4'b0000, no submit -> after 20 ANSWER cycles correct pulses; a repeat round that submits sw=4'b0001 -> wrong.
- Submit edge in the same cycle as timer==0 with a correct sw -> graded correct, not timeout-wrong.
- Three consecutive wrong rounds -> lives=0, game_over=1 after SHOW; further prompt_valid ignored; start -> score 0, lives 3, next_prompt pulses.
- Preload 99 correct rounds, then one more correct -> score_bcd stays 8'h99; 09->10 carry checked; reset asserted mid-ANSWER -> all outputs 0 next cycle.
